// File: rtl/pipeline_flush_unit.sv
// pipeline_flush_unit
//   Owns the fetch PC and the IF/ID pipeline register of the 5-stage RISC-V
//   core. It resolves EX control-hazard flushes and ID load-use stalls, and it
//   counts both kinds of event.
//   Per-edge priority is flush > stall > advance.
//
// Ports:
//   clk              core clock, rising edge
//   rst_n            asynchronous active-low reset
//   Cr_pipeline_stop flush request from EX (combinational, valid each cycle)
//   ex_redirect_pc   branch/jump target from EX, qualified by Cr_pipeline_stop
//   Dr_stall         load-use stall request from ID
//   if_inst          instruction read combinationally from IROM at pc
//   pc               current fetch PC
//   id_pc, id_pc4    PC (and PC+4) of the instruction held in ID
//   id_inst          instruction held in ID
//   id_valid         1 = real instruction in ID, 0 = bubble
//   idex_flush       ID/EX loads a bubble at the next edge (combinational)
//   flush_cnt        accepted flushes, saturating
//   stall_cnt        stall cycles, saturating
module pipeline_flush_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Cr_pipeline_stop,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             Dr_stall,
    input  logic [31:0]      if_inst,
    output logic [31:0]      pc,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             idex_flush,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, FLUSHED} state_t;

    state_t      state;
    logic        eff_flush;
    logic [31:0] pc_plus4;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // In FLUSHED, EX holds the bubble injected by the previous flush, so a
    // request seen there is stale and must be ignored.
    assign eff_flush  = Cr_pipeline_stop & (state == RUN);
    assign idex_flush = rst_n & (eff_flush | Dr_stall);
    assign pc_plus4   = pc + 32'd4;

    // Fetch / IF-ID stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= PC_RESET;
            id_pc     <= 32'd0;
            id_pc4    <= 32'd0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            flush_cnt <= '0;
            stall_cnt <= '0;
            state     <= RUN;
        end else if (eff_flush) begin
            // The redirect target is the only use of ex_redirect_pc, so an
            // unqualified (possibly X) target never reaches pc.
            pc        <= {ex_redirect_pc[31:2], 2'b00};
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            flush_cnt <= sat_inc(flush_cnt);
            state     <= FLUSHED;
        end else if (Dr_stall) begin
            stall_cnt <= sat_inc(stall_cnt);
            state     <= RUN;
        end else begin
            pc       <= pc_plus4;
            id_pc    <= pc;
            id_pc4   <= pc_plus4;
            id_inst  <= if_inst;
            id_valid <= 1'b1;
            state    <= RUN;
        end
    end

endmodule

// File: tb/tb_pipeline_flush_unit.sv
module tb_pipeline_flush_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Cr_pipeline_stop;
    logic [31:0] ex_redirect_pc;
    logic        Dr_stall;
    logic [31:0] if_inst;
    logic [31:0] pc, id_pc, id_pc4, id_inst;
    logic        id_valid, idex_flush;
    logic [31:0] flush_cnt, stall_cnt;
    logic [31:0] pc2, id_pc2, id_pc4_2, id_inst2;
    logic        id_valid2, idex_flush2;
    logic [1:0]  flush_cnt2, stall_cnt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // IROM model: instruction word derived from the fetch address.
    assign if_inst = pc | 32'h1000_0000;

    pipeline_flush_unit dut (
        .clk(clk), .rst_n(rst_n), .Cr_pipeline_stop(Cr_pipeline_stop),
        .ex_redirect_pc(ex_redirect_pc), .Dr_stall(Dr_stall), .if_inst(if_inst),
        .pc(pc), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .id_valid(id_valid), .idex_flush(idex_flush),
        .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipeline_flush_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Cr_pipeline_stop(Cr_pipeline_stop),
        .ex_redirect_pc(ex_redirect_pc), .Dr_stall(Dr_stall), .if_inst(if_inst),
        .pc(pc2), .id_pc(id_pc2), .id_pc4(id_pc4_2), .id_inst(id_inst2),
        .id_valid(id_valid2), .idex_flush(idex_flush2),
        .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        Cr_pipeline_stop = 1'b0;
        ex_redirect_pc = 32'd0;
        Dr_stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_id_inst", id_inst, 32'h13);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        Dr_stall = 1'b1;
        #1 chk("rst_idex_flush_masked", {31'd0, idex_flush}, 32'd0);
        step();
        chk("rst_hold_pc", pc, 32'h0);
        Dr_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running fetch
        step();
        chk("adv1_pc", pc, 32'h4);
        chk("adv1_id_pc", id_pc, 32'h0);
        chk("adv1_id_pc4", id_pc4, 32'h4);
        chk("adv1_id_inst", id_inst, 32'h1000_0000);
        chk("adv1_id_valid", {31'd0, id_valid}, 32'd1);
        chk("adv1_idex_flush", {31'd0, idex_flush}, 32'd0);
        step();
        chk("adv2_pc", pc, 32'h8);
        chk("adv2_id_pc", id_pc, 32'h4);
        step();
        chk("adv3_pc", pc, 32'hC);
        chk("adv3_id_pc", id_pc, 32'h8);
        chk("adv3_idex_flush", {31'd0, idex_flush}, 32'd0);
        step();
        chk("adv4_pc", pc, 32'h10);

        // Single flush at pc=0x10
        Cr_pipeline_stop = 1'b1;
        ex_redirect_pc = 32'h200;
        #1 chk("fl1_idex_flush", {31'd0, idex_flush}, 32'd1);
        step();
        Cr_pipeline_stop = 1'b0;
        chk("fl1_pc", pc, 32'h200);
        chk("fl1_id_inst", id_inst, 32'h13);
        chk("fl1_id_valid", {31'd0, id_valid}, 32'd0);
        chk("fl1_id_pc_hold", id_pc, 32'hC);
        chk("fl1_flush_cnt", flush_cnt, 32'd1);
        step();
        chk("fl1_next_pc", pc, 32'h204);
        chk("fl1_next_id_pc", id_pc, 32'h200);
        chk("fl1_next_id_inst", id_inst, 32'h1000_0200);
        chk("fl1_next_id_valid", {31'd0, id_valid}, 32'd1);

        // Request held for two cycles: the second is masked
        Cr_pipeline_stop = 1'b1;
        ex_redirect_pc = 32'h200;
        step();
        chk("fl2_pc", pc, 32'h200);
        ex_redirect_pc = 32'h300;
        #1 chk("fl2_masked_idex_flush", {31'd0, idex_flush}, 32'd0);
        step();
        Cr_pipeline_stop = 1'b0;
        chk("fl2_masked_pc", pc, 32'h204);
        chk("fl2_flush_cnt", flush_cnt, 32'd2);

        // Move to pc=0x40 with 0x3C in ID
        Cr_pipeline_stop = 1'b1;
        ex_redirect_pc = 32'h3C;
        step();
        Cr_pipeline_stop = 1'b0;
        step();
        chk("pre_stall_pc", pc, 32'h40);
        chk("pre_stall_id_pc", id_pc, 32'h3C);

        // Three stall cycles
        Dr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_idex_flush", {31'd0, idex_flush}, 32'd1);
            step();
            chk("stall_pc", pc, 32'h40);
            chk("stall_id_pc", id_pc, 32'h3C);
            chk("stall_id_inst", id_inst, 32'h1000_003C);
        end
        Dr_stall = 1'b0;
        chk("stall_cnt3", stall_cnt, 32'd3);
        step();
        chk("stall_resume_pc", pc, 32'h44);
        chk("stall_resume_id_pc", id_pc, 32'h40);

        // Flush and stall together: flush wins, target aligned
        Cr_pipeline_stop = 1'b1;
        Dr_stall = 1'b1;
        ex_redirect_pc = 32'h81;
        #1 chk("both_idex_flush", {31'd0, idex_flush}, 32'd1);
        step();
        chk("both_pc", pc, 32'h80);
        chk("both_id_inst", id_inst, 32'h13);
        chk("both_id_valid", {31'd0, id_valid}, 32'd0);
        chk("both_flush_cnt", flush_cnt, 32'd4);
        chk("both_stall_cnt", stall_cnt, 32'd3);

        // Stall inside FLUSHED (stop still high but masked), then stop honoured
        ex_redirect_pc = 32'h400;
        step();
        chk("flushed_stall_pc", pc, 32'h80);
        chk("flushed_stall_cnt", stall_cnt, 32'd4);
        chk("flushed_stall_flush_cnt", flush_cnt, 32'd4);
        Dr_stall = 1'b0;
        step();
        Cr_pipeline_stop = 1'b0;
        chk("after_flushed_pc", pc, 32'h400);
        chk("after_flushed_flush_cnt", flush_cnt, 32'd5);

        // Unknown target while not flushing
        ex_redirect_pc = 32'hxxxx_xxxx;
        step();
        chk("x_target_pc", pc, 32'h404);

        // Wrap-around
        Cr_pipeline_stop = 1'b1;
        ex_redirect_pc = 32'hFFFF_FFFC;
        step();
        Cr_pipeline_stop = 1'b0;
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc4", id_pc4, 32'h0);
        chk("sat_flush_cnt2", {30'd0, flush_cnt2}, 32'd3);
        chk("sat_stall_cnt2", {30'd0, stall_cnt2}, 32'd3);
        step();
        step();
        chk("pre_rst_pc", pc, 32'h8);

        // Asynchronous reset in the middle of a flush cycle
        Cr_pipeline_stop = 1'b1;
        ex_redirect_pc = 32'h500;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_flush_cnt", flush_cnt, 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
        chk("mid_rst_id_inst", id_inst, 32'h13);
        chk("mid_rst_idex_flush", {31'd0, idex_flush}, 32'd0);
        Cr_pipeline_stop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_pc", pc, 32'h4);

        // Five flushes: wide counter counts, narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            Cr_pipeline_stop = 1'b1;
            ex_redirect_pc = 32'(i + 1) << 8;
            step();
            Cr_pipeline_stop = 1'b0;
            step();
        end
        chk("five_flush_cnt", flush_cnt, 32'd5);
        chk("five_flush_cnt2", {30'd0, flush_cnt2}, 32'd3);
        chk("five_pc", pc, 32'h504);
        Dr_stall = 1'b1;
        repeat (4) step();
        Dr_stall = 1'b0;
        chk("four_stall_cnt", stall_cnt, 32'd4);
        chk("four_stall_cnt2", {30'd0, stall_cnt2}, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_flush_unit.md
Name: pipeline_flush_unit

Overview:
- Owns the fetch PC register and the IF/ID pipeline register of the 5-stage RISC-V pipeline.
- Consumes the EX-stage control-hazard flush request (Cr_pipeline_stop) and the load-use stall request.
- On a flush it redirects the PC and injects bubbles; on a stall it freezes fetch and drives the ID/EX clear.
- Also keeps flush and stall event counters for performance inspection.

Parameters:
- PC_RESET, 32'h0000_0000, fetch PC after reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID
- CNT_W, 32, width of the event counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Cr_pipeline_stop  in  1  control-hazard flush request from EX, combinational, valid each cycle
- ex_redirect_pc  in  32  branch/jump target computed in EX, qualified by Cr_pipeline_stop
- Dr_stall  in  1  load-use stall request from ID
- if_inst  in  32  instruction read combinationally from IROM at pc
- pc  out  32  current fetch PC
- id_pc  out  32  PC of instruction in ID
- id_pc4  out  32  id_pc+4
- id_inst  out  32  instruction in ID
- id_valid  out  1  1 = ID holds a real instruction, 0 = bubble
- idex_flush  out  1  combinational; ID/EX register loads a bubble at the next edge
- flush_cnt  out  CNT_W  number of accepted flushes
- stall_cnt  out  CNT_W  number of stall cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=PC_RESET; id_pc=0; id_pc4=0; id_inst=NOP_INST; id_valid=0.
  - flush_cnt=0; stall_cnt=0; state=RUN.
  - idex_flush is driven 0 while in reset.
- FSM states RUN and FLUSHED, registered.
- Effective flush: eff_flush = Cr_pipeline_stop & (state==RUN). Cr_pipeline_stop is masked in FLUSHED, because EX holds the bubble injected by the previous flush.
- idex_flush = eff_flush | Dr_stall, combinational, same cycle.
- Per-edge priority: flush > stall > advance.
  - Flush (eff_flush=1, Dr_stall ignored):
    - pc <= {ex_redirect_pc[31:2],2'b00}.
    - id_inst <= NOP_INST; id_valid <= 0; id_pc and id_pc4 hold.
    - flush_cnt increments; state <= FLUSHED.
  - Stall (eff_flush=0, Dr_stall=1):
    - pc, id_pc, id_pc4, id_inst, id_valid all hold.
    - stall_cnt increments.
    - State: RUN stays RUN; FLUSHED goes to RUN.
  - Advance (neither):
    - pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
    - id_pc <= pc; id_pc4 <= pc+4; id_inst <= if_inst; id_valid <= 1.
    - state <= RUN.
- FLUSHED lasts exactly one cycle and always returns to RUN at the next edge. Stall and advance behave normally within it.
- Counters saturate at all-ones and never wrap.
- Latency:
  - Redirect target is the fetch PC one cycle after the flush request.
  - First redirected instruction reaches ID two cycles after the request.
- Reset asserted mid-flush or mid-stall: immediate return to reset values, with no pending redirect retained.
- X on ex_redirect_pc while Cr_pipeline_stop=0 must not propagate to pc.

Test Plan:
- Reset release, no hazards, IROM returns inst=pc|32'h1000_0000 -> pc 0,4,8,C on successive edges; id_pc lags pc by one; id_valid=1 from the second cycle; idex_flush=0 throughout.
- Cr_pipeline_stop=1 for one cycle at pc=0x10, ex_redirect_pc=0x200 -> next pc=0x200; id_inst=0x00000013, id_valid=0; flush_cnt=1; the following edge loads id_pc=0x200.
- Cr_pipeline_stop held high two cycles, targets 0x200 then 0x300 -> second request masked; pc goes 0x200 then 0x204; flush_cnt=1.
- Dr_stall=1 for 3 cycles at pc=0x40 -> pc and IF/ID frozen; idex_flush=1 each cycle; stall_cnt=3; advance resumes at pc=0x44.
- Cr_pipeline_stop=1 and Dr_stall=1 together, target 0x81 -> flush wins: pc=0x80, IF/ID bubbled, flush_cnt+1, stall_cnt unchanged.
- pc=0xFFFF_FFFC advance -> pc=0; then rst_n pulsed low mid-cycle during a flush -> pc immediately PC_RESET, counters 0; CNT_W=2 with 5 flushes -> flush_cnt=3.
